// File: rtl/regfile_onchip_arbiter_if.sv
// Avalon-MM master-to-slave bundle used by each register-file master.
// The arbiter sees each master through the slave modport.
interface regfile_onchip_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/regfile_onchip_arbiter.sv
// Round-robin arbiter sharing one single-port register-file RAM between two masters.
// m1 can lock the RAM for read-modify-write; the lock is forcibly dropped after LOCK_MAX cycles.
module regfile_onchip_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_onchip_arbiter_if.slave m0,
  regfile_onchip_arbiter_if.slave m1,
  input  logic                m1_lock,
  output logic                lock_timeout,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state, state_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic             last_grant, last_grant_next;
  logic             lock_blocked, lock_blocked_next;
  logic             rd_pend0, rd_pend1;
  logic             req0, req1, grant0, grant1;

  // last_grant = 1 means m1 won most recently, so m0 wins the next contention
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= UNLOCKED;
      lock_cnt     <= '0;
      last_grant   <= 1'b1;
      lock_blocked <= 1'b0;
      rd_pend0     <= 1'b0;
      rd_pend1     <= 1'b0;
    end else begin
      state        <= state_next;
      lock_cnt     <= lock_cnt_next;
      last_grant   <= last_grant_next;
      lock_blocked <= lock_blocked_next;
      rd_pend0     <= grant0 & m0.read & ~m0.write;
      rd_pend1     <= grant1 & m1.read & ~m1.write;
    end
  end

  always_comb begin
    req0              = m0.read | m0.write;
    req1              = m1.read | m1.write;
    grant0            = 1'b0;
    grant1            = 1'b0;
    state_next        = state;
    lock_cnt_next     = lock_cnt;
    last_grant_next   = last_grant;
    lock_blocked_next = lock_blocked;
    lock_timeout      = reset_n && (state == LOCKED) &&
                        (lock_cnt == CNT_W'(LOCK_MAX - 1));

    if (reset_n) begin
      if (state == LOCKED) begin
        grant1 = req1;
      end else if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end

    if (grant0)
      last_grant_next = 1'b0;
    else if (grant1)
      last_grant_next = 1'b1;

    // After a forced release the lock request is ignored until m1 drops it once
    if (!m1_lock)
      lock_blocked_next = 1'b0;

    case (state)
      UNLOCKED: begin
        if (grant1 && m1_lock && !lock_blocked) begin
          state_next    = LOCKED;
          lock_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (lock_timeout) begin
          state_next        = UNLOCKED;
          lock_cnt_next     = '0;
          lock_blocked_next = 1'b1;
          last_grant_next   = 1'b1;
        end else if (!m1_lock) begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + CNT_W'(1);
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_comb begin
    ram_chipselect = grant0 | grant1;
    ram_address    = m0.address;
    ram_writedata  = m0.writedata;
    ram_write      = grant0 & m0.write;
    ram_byteenable = m0.write ? m0.byteenable : {BE_W{1'b1}};
    if (grant1) begin
      ram_address    = m1.address;
      ram_writedata  = m1.writedata;
      ram_write      = m1.write;
      ram_byteenable = m1.write ? m1.byteenable : {BE_W{1'b1}};
    end
  end

  assign m0.waitrequest   = req0 & ~grant0;
  assign m1.waitrequest   = req1 & ~grant1;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = rd_pend0 & reset_n;
  assign m1.readdatavalid = rd_pend1 & reset_n;
endmodule
